// File: rtl/ntt_core_loader.sv
// Purpose: packs a 30-bit coefficient stream into 60-bit word pairs for one NTT core's upper/lower BRAM banks.
// Latency: a write is issued 1 cycle after each odd coefficient is accepted; done pulses 2 cycles after the final accept.
// Backpressure: in_ready is high only while loading; the stream stalls on bubbles and takes at most 1 coefficient per cycle.
// Optional: define NTT_LOADER_MODRED_EN to reduce coefficients >= Q once and to flag them on the sticky range_err.
module ntt_core_loader #(
  parameter int                LOG_WORDS = 9,
  parameter int                DATA_W    = 30,
  parameter logic [DATA_W-1:0] Q         = 30'd1073479681
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   upper_write_enable,
  output logic [LOG_WORDS-1:0]   upper_write_address,
  output logic [2*DATA_W-1:0]    upper_data_input,
  output logic                   lower_write_enable,
  output logic [LOG_WORDS-1:0]   lower_write_address,
  output logic [2*DATA_W-1:0]    lower_data_input,
  output logic                   busy,
  output logic                   done,
  output logic                   range_err
);

  localparam int CW = LOG_WORDS + 2;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] coef;
  logic              accept;
  logic              last;

  assign in_ready = (state == LOAD);
  assign accept   = in_valid && in_ready;
  assign last     = &cnt;
  assign busy     = (state != IDLE);

  // Coefficient as it will be held or packed (optionally reduced once by Q).
`ifdef NTT_LOADER_MODRED_EN
  logic over_q;
  assign over_q = (in_data >= Q);
  always_comb begin
    coef = in_data;
    if (over_q) coef = in_data - Q;
  end
`else
  always_comb begin
    coef = in_data;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: LOAD leaves exactly on the last accept, so the counter never wraps.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && last) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter, even-coefficient hold, registered bank writes and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt                 <= '0;
      hold                <= '0;
      done                <= 1'b0;
      upper_write_enable  <= 1'b0;
      upper_write_address <= '0;
      upper_data_input    <= '0;
      lower_write_enable  <= 1'b0;
      lower_write_address <= '0;
      lower_data_input    <= '0;
    end else begin
      done               <= (state == FLUSH);
      upper_write_enable <= 1'b0;
      lower_write_enable <= 1'b0;
      if (state == IDLE && start) cnt <= '0;
      if (accept) begin
        cnt <= cnt + 1'b1;
        if (!cnt[0]) begin
          hold <= coef;
        end else if (cnt[1]) begin
          lower_write_enable  <= 1'b1;
          lower_write_address <= cnt[CW-1:2];
          lower_data_input    <= {coef, hold};
        end else begin
          upper_write_enable  <= 1'b1;
          upper_write_address <= cnt[CW-1:2];
          upper_data_input    <= {coef, hold};
        end
      end
    end
  end

`ifdef NTT_LOADER_MODRED_EN
  // Sticky out-of-range flag, cleared when a new block load begins.
  always_ff @(posedge clk) begin
    if (rst)                         range_err <= 1'b0;
    else if (state == IDLE && start) range_err <= 1'b0;
    else if (accept && over_q)       range_err <= 1'b1;
  end
`else
  // Without reduction the modulus has no consumer.
  logic unused_q;
  assign unused_q  = ^Q;
  assign range_err = 1'b0;
`endif

endmodule
